vload_sequencer: RTL and testbench
==================================

Name: vload_sequencer

Overview:
- Sequences multi-word vector loads from the single-word data ROM (`dmem_rom2` class).
  - That ROM returns one S-bit word per address, zero-extended into a V-bit bus.
- The block walks a strided address sequence, one ROM read per cycle, and packs the words into lanes of a V-bit vector.
- It hands the packed vector to the vector register file / load unit over a valid/ready handshake.
- It sits between the vector load/store decode stage and the data ROM, and is the only driver of the ROM address.

Parameters:
- S, 32, scalar word width in bits; equals the ROM word width.
- V, 192, vector width in bits; LANES = V/S = 6. V must be an integer multiple of S.
- SIZE, 30015, number of valid ROM words; addresses >= SIZE are out of range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  load request valid.
- req_ready  output  1  sequencer can accept a request.
- req_base  input  S  word address of lane 0.
- req_stride  input  S  word-address increment between lanes; unsigned, wraps mod 2^S.
- req_count  input  $clog2(LANES+1)  lanes to load. 0 or values > LANES mean LANES.
- rom_addr  output  S  address to ROM (combinational ROM, 0 cycles of read latency).
- rom_rd  input  V  ROM read data; only bits [S-1:0] are used.
- resp_valid  output  1  packed vector valid.
- resp_ready  input  1  consumer accepts the vector.
- resp_data  output  V  packed vector. Lane i is at bits [i*S +: S]; unloaded lanes are 0.
- resp_err  output  1  at least one lane address was >= SIZE.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. Outputs: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, rom_addr=0, busy=0. All internal registers (lane index, current address, stride, count, data and error accumulators) are cleared.
- Reset asserted mid-load or during DONE aborts the transaction. No response is produced.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch base into cur_addr, latch stride, latch the effective count N (1..LANES).
  - Clear the data and error accumulators, set idx=0, go to LOAD.
- LOAD:
  - req_ready=0. rom_addr = cur_addr if cur_addr < SIZE, else 0.
  - Each cycle, lane idx is loaded with rom_rd[S-1:0] if cur_addr < SIZE. Otherwise the lane gets 0 and the error accumulator is set.
  - Then idx += 1 and cur_addr += stride (mod 2^S).
  - When idx == N-1 is captured, go to DONE.
- DONE:
  - resp_valid=1; resp_data and resp_err are held stable while resp_ready=0.
  - On resp_ready: go to IDLE, drop resp_valid, clear resp_data to 0.
- Outside LOAD, rom_addr = 0.
- Latency: request accepted at edge T, resp_valid is first high in cycle T+N+1.
- Throughput: no request overlap. req_ready is 0 in LOAD and DONE, and returns to 1 in the cycle after the response handshake.
- Address wrap: cur_addr + stride wraps mod 2^S. A wrapped address is only in range if it is < SIZE.
- Stride 0 is legal: all N lanes read the same word.
- req_valid is ignored in LOAD and DONE. The requester must hold its request until req_ready.
- Lane bound: idx never exceeds LANES-1 regardless of req_count.

Decomposition:
- Shared package vec_pkg:
  - Constants S, V, LANES, DMEM_SIZE.
  - typedef word_t = logic[S-1:0]; vec_t = logic[V-1:0].
  - enum vload_state_e {IDLE, LOAD, DONE}.
  - Function eff_count(req_count) returning the effective count N.
- One natural sub-module: vlane_packer.
  - Holds the V-bit accumulator.
  - Writes the S-bit word into lane idx on a write enable; clears on start.
- The FSM and address generator stay in vload_sequencer.

Test Plan:
- Contiguous load:
  - Stimulus: ROM[i]=i+100; request base=10, stride=1, count=6.
  - Response: resp_data lanes 0..5 = 110..115, resp_err=0, resp_valid at T+7; rom_addr steps 10..15 on consecutive cycles.
- Strided, partial load:
  - Stimulus: base=0, stride=150, count=3.
  - Response: lanes 0..2 = ROM[0], ROM[150], ROM[300]; lanes 3..5 = 0; resp_valid at T+4.
- Out of range:
  - Stimulus: base=30013, stride=1, count=4.
  - Response: lanes 0,1 = ROM[30013], ROM[30014]; lanes 2,3 = 0; resp_err=1; rom_addr=0 in those two cycles.
- Count saturation and wrap:
  - Stimulus: count=0, then count=7; base=0xFFFFFFFF, stride=2.
  - Response: both count values load 6 lanes. Lane 0 errors; lane 1 reads address 1 = ROM[1].
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles, with req_valid pulsed during DONE.
  - Response: resp_data and resp_err stable; req_ready=0; the request is not accepted. After resp_ready: IDLE, and req_ready=1 the next cycle.
- Reset mid-load:
  - Stimulus: rst_n=0 asynchronously at idx=3.
  - Response: immediately resp_valid=0, busy=0, req_ready=1, resp_data=0. A new request after release completes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// ----------------------------------------------------------------------------
// vec_pkg: shared constants, types and helpers for the vector load sequencer.
//   S         scalar / ROM word width
//   V         vector width, LANES = V/S lanes
//   DMEM_SIZE number of valid ROM words (addresses >= DMEM_SIZE are invalid)
// ----------------------------------------------------------------------------
package vec_pkg;

   localparam int S         = 32;
   localparam int V         = 192;
   localparam int LANES     = V / S;
   localparam int DMEM_SIZE = 30015;
   localparam int CNT_W     = $clog2(LANES + 1);
   localparam int IDX_W     = $clog2(LANES);

   typedef logic [S-1:0]     word_t;
   typedef logic [V-1:0]     vec_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } vload_state_e;

   // Requested lane count, with 0 and anything above LANES meaning a full vector.
   function automatic cnt_t eff_count(input cnt_t req_count);
      cnt_t n_v;
      if ((req_count == cnt_t'(0)) || (req_count > cnt_t'(LANES))) begin
         n_v = cnt_t'(LANES);
      end else begin
         n_v = req_count;
      end
      return n_v;
   endfunction

   // True when the word address lies inside the ROM.
   function automatic logic in_range(input word_t addr);
      return (addr < word_t'(DMEM_SIZE));
   endfunction

endpackage

// File: rtl/vload_sequencer_if.sv
// ----------------------------------------------------------------------------
// vload_sequencer_if: request and response handshakes of the sequencer.
//   req_*  : load request (valid/ready, base, stride, count)
//   resp_* : packed vector response (valid/ready, data, err)
//   master : decode stage / consumer side;  slave : the sequencer
// ----------------------------------------------------------------------------
interface vload_sequencer_if;
   import vec_pkg::*;

   logic  req_valid;
   logic  req_ready;
   word_t req_base;
   word_t req_stride;
   cnt_t  req_count;
   logic  resp_valid;
   logic  resp_ready;
   vec_t  resp_data;
   logic  resp_err;

   modport master (
      output req_valid, req_base, req_stride, req_count, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_base, req_stride, req_count, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/vload_sequencer_packer.sv
// ----------------------------------------------------------------------------
// vlane_packer: V-bit accumulator that drops one S-bit word into lane idx.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the whole vector (start of load / response taken)
//   wr_en      : write word into lane idx
//   idx, word  : lane index and word to write
//   data       : accumulated vector (registered)
// ----------------------------------------------------------------------------
module vlane_packer
   import vec_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  wr_en,
   input  idx_t  idx,
   input  word_t word,
   output vec_t  data
);

   vec_t data_r;

   // Lane accumulator: clear takes priority over a lane write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= {V{1'b0}};
      end else if (clr) begin
         data_r <= {V{1'b0}};
      end else if (wr_en && (idx < idx_t'(LANES))) begin
         data_r[idx*S +: S] <= word;
      end else begin
         data_r <= data_r;
      end
   end

   assign data = data_r;

endmodule

// File: rtl/vload_sequencer.sv
// ----------------------------------------------------------------------------
// vload_sequencer: walks a strided word-address sequence through the data ROM,
// one read per cycle, and packs the words into a V-bit vector.
//   clk, rst_n : clock, async active-low reset
//   bus        : request/response handshakes (slave side)
//   rom_addr   : ROM word address (0 outside LOAD or when out of range)
//   rom_rd     : ROM read data, only the low S bits are meaningful
//   busy       : FSM is not IDLE
// ----------------------------------------------------------------------------
module vload_sequencer
   import vec_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   vload_sequencer_if.slave  bus,
   output word_t             rom_addr,
   input  vec_t              rom_rd,
   output logic              busy
);

   vload_state_e state_r;
   word_t        cur_addr_r;
   word_t        stride_r;
   cnt_t         count_r;
   idx_t         idx_r;
   logic         err_r;
   logic         req_ready_r;
   logic         resp_valid_r;
   logic         busy_r;
   word_t        rom_addr_r;

   word_t        next_addr_s;
   logic         cur_ok_s;
   logic         accept_s;
   logic         taken_s;
   logic         lane_wr_s;
   word_t        lane_word_s;
   logic         unused_rom_hi_s;

   assign next_addr_s = cur_addr_r + stride_r;
   assign cur_ok_s    = in_range(cur_addr_r);
   assign accept_s    = (state_r == IDLE) && bus.req_valid;
   assign taken_s     = (state_r == DONE) && bus.resp_ready;
   assign lane_wr_s   = (state_r == LOAD);
   // Out-of-range lanes are written as zero so a stale ROM value never leaks in.
   assign lane_word_s = cur_ok_s ? rom_rd[S-1:0] : word_t'(0);
   assign unused_rom_hi_s = ^rom_rd[V-1:S];

   // Sequencer FSM, address generator and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cur_addr_r   <= word_t'(0);
         stride_r     <= word_t'(0);
         count_r      <= cnt_t'(0);
         idx_r        <= idx_t'(0);
         err_r        <= 1'b0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         rom_addr_r   <= word_t'(0);
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  cur_addr_r  <= bus.req_base;
                  stride_r    <= bus.req_stride;
                  count_r     <= eff_count(bus.req_count);
                  idx_r       <= idx_t'(0);
                  err_r       <= 1'b0;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  // rom_addr is registered, so the lane-0 address is set up here.
                  rom_addr_r  <= in_range(bus.req_base) ? bus.req_base : word_t'(0);
                  state_r     <= LOAD;
               end else begin
                  state_r     <= IDLE;
               end
            end
            LOAD: begin
               if (!cur_ok_s) begin
                  err_r <= 1'b1;
               end else begin
                  err_r <= err_r;
               end
               idx_r      <= idx_r + idx_t'(1);
               cur_addr_r <= next_addr_s;
               if (cnt_t'(idx_r) == (count_r - cnt_t'(1))) begin
                  resp_valid_r <= 1'b1;
                  rom_addr_r   <= word_t'(0);
                  state_r      <= DONE;
               end else begin
                  rom_addr_r   <= in_range(next_addr_s) ? next_addr_s : word_t'(0);
                  state_r      <= LOAD;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= IDLE;
               end else begin
                  state_r      <= DONE;
               end
            end
            default: begin
               state_r      <= IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               rom_addr_r   <= word_t'(0);
            end
         endcase
      end
   end

   vlane_packer u_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept_s | taken_s),
      .wr_en (lane_wr_s),
      .idx   (idx_r),
      .word  (lane_word_s),
      .data  (bus.resp_data)
   );

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_err   = err_r;
   assign rom_addr       = rom_addr_r;
   assign busy           = busy_r;

endmodule

// File: tb/tb_vload_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vload_sequencer: directed bench for vload_sequencer. The ROM model
// returns addr+100 for every address, so masking of out-of-range lanes is
// visible. Expected vectors are written out by hand.
// ----------------------------------------------------------------------------
module tb_vload_sequencer;

   logic         clk;
   logic         rst_n;
   logic [31:0]  rom_addr;
   logic [191:0] rom_rd;
   logic         busy;
   logic [31:0]  addr_seen [0:31];
   logic [191:0] hold_data;
   int           lat;
   int           errors;
   int           checks;

   vload_sequencer_if bus ();

   vload_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .rom_addr (rom_addr),
      .rom_rd   (rom_rd),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ROM: ROM[i] = i + 100.
   always_comb rom_rd = {160'd0, rom_addr + 32'd100};

   function automatic logic [191:0] pack6(input logic [31:0] l0, l1, l2, l3, l4, l5);
      return {l5, l4, l3, l2, l1, l0};
   endfunction

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request, let it be accepted, then wait (bounded) for resp_valid,
   // recording rom_addr in each cycle before the response.
   task automatic run_req(input logic [31:0] base, input logic [31:0] stride, input logic [2:0] cnt);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_base   = base;
      bus.req_stride = stride;
      bus.req_count  = cnt;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      for (int k = 0; k < 32; k++) addr_seen[k] = 32'hDEAD_BEEF;
      lat = 0;
      while ((bus.resp_valid !== 1'b1) && (lat < 20)) begin
         addr_seen[lat] = rom_addr;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   // Take the response and check the block is back in IDLE the next cycle.
   task automatic take_resp(input string tag);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk({tag, "_rv0"},  {191'd0, bus.resp_valid}, 192'd0);
      chk({tag, "_rr1"},  {191'd0, bus.req_ready},  192'd1);
      chk({tag, "_data0"}, bus.resp_data,           192'd0);
      chk({tag, "_busy0"}, {191'd0, busy},          192'd0);
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_base   = 32'd0;
      bus.req_stride = 32'd0;
      bus.req_count  = 3'd0;
      bus.resp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready",  {191'd0, bus.req_ready},  192'd1);
      chk("rst_resp_valid", {191'd0, bus.resp_valid}, 192'd0);
      chk("rst_resp_data",  bus.resp_data,            192'd0);
      chk("rst_resp_err",   {191'd0, bus.resp_err},   192'd0);
      chk("rst_rom_addr",   {160'd0, rom_addr},       192'd0);
      chk("rst_busy",       {191'd0, busy},           192'd0);
      rst_n = 1'b1;

      // Contiguous load: base 10, stride 1, 6 lanes
      run_req(32'd10, 32'd1, 3'd6);
      chk("contig_lat",  lat, 192'd6);
      for (int k = 0; k < 6; k++) chk("contig_addr", {160'd0, addr_seen[k]}, 192'(10 + k));
      chk("contig_data", bus.resp_data, pack6(32'd110, 32'd111, 32'd112, 32'd113, 32'd114, 32'd115));
      chk("contig_err",  {191'd0, bus.resp_err}, 192'd0);
      chk("contig_rr0",  {191'd0, bus.req_ready}, 192'd0);
      chk("contig_done_addr", {160'd0, rom_addr}, 192'd0);
      take_resp("contig");

      // Strided partial load: base 0, stride 150, 3 lanes
      run_req(32'd0, 32'd150, 3'd3);
      chk("stride_lat",  lat, 192'd3);
      chk("stride_data", bus.resp_data, pack6(32'd100, 32'd250, 32'd400, 32'd0, 32'd0, 32'd0));
      chk("stride_err",  {191'd0, bus.resp_err}, 192'd0);
      take_resp("stride");

      // Out of range tail: base 30013, stride 1, 4 lanes
      run_req(32'd30013, 32'd1, 3'd4);
      chk("oor_lat",   lat, 192'd4);
      chk("oor_addr0", {160'd0, addr_seen[0]}, 192'd30013);
      chk("oor_addr1", {160'd0, addr_seen[1]}, 192'd30014);
      chk("oor_addr2", {160'd0, addr_seen[2]}, 192'd0);
      chk("oor_addr3", {160'd0, addr_seen[3]}, 192'd0);
      chk("oor_data",  bus.resp_data, pack6(32'd30113, 32'd30114, 32'd0, 32'd0, 32'd0, 32'd0));
      chk("oor_err",   {191'd0, bus.resp_err}, 192'd1);
      take_resp("oor");

      // Count 0 saturates to 6; base wraps from 0xFFFFFFFF
      run_req(32'hFFFF_FFFF, 32'd2, 3'd0);
      chk("c0_lat",  lat, 192'd6);
      chk("c0_addr1", {160'd0, addr_seen[1]}, 192'd1);
      chk("c0_data", bus.resp_data, pack6(32'd0, 32'd101, 32'd103, 32'd105, 32'd107, 32'd109));
      chk("c0_err",  {191'd0, bus.resp_err}, 192'd1);
      take_resp("c0");

      // Count 7 also saturates to 6
      run_req(32'hFFFF_FFFF, 32'd2, 3'd7);
      chk("c7_lat",  lat, 192'd6);
      chk("c7_data", bus.resp_data, pack6(32'd0, 32'd101, 32'd103, 32'd105, 32'd107, 32'd109));
      chk("c7_err",  {191'd0, bus.resp_err}, 192'd1);
      take_resp("c7");

      // Backpressure with a request pulsed during DONE
      run_req(32'd20, 32'd1, 3'd2);
      chk("bp_lat", lat, 192'd2);
      hold_data = pack6(32'd120, 32'd121, 32'd0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_data",  bus.resp_data, hold_data);
         chk("bp_err",   {191'd0, bus.resp_err},   192'd0);
         chk("bp_valid", {191'd0, bus.resp_valid}, 192'd1);
         chk("bp_rr0",   {191'd0, bus.req_ready},  192'd0);
         bus.req_valid  = ((k == 1) || (k == 2)) ? 1'b1 : 1'b0;
         bus.req_base   = 32'd500;
         bus.req_count  = 3'd1;
         @(posedge clk);
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      chk("bp_data_end", bus.resp_data, hold_data);
      take_resp("bp");
      @(posedge clk);
      @(negedge clk);
      chk("bp_no_accept", {191'd0, busy}, 192'd0);

      // Asynchronous reset once three lanes have been captured
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_base   = 32'd40;
      bus.req_stride = 32'd1;
      bus.req_count  = 3'd6;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {191'd0, bus.resp_valid}, 192'd0);
      chk("mid_rst_busy",  {191'd0, busy},           192'd0);
      chk("mid_rst_rr",    {191'd0, bus.req_ready},  192'd1);
      chk("mid_rst_data",  bus.resp_data,            192'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req(32'd5, 32'd3, 3'd2);
      chk("post_rst_lat",  lat, 192'd2);
      chk("post_rst_data", bus.resp_data, pack6(32'd105, 32'd108, 32'd0, 32'd0, 32'd0, 32'd0));
      chk("post_rst_err",  {191'd0, bus.resp_err}, 192'd0);
      take_resp("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
